regbus_arbiter: RTL and testbench

Two-port arbiter and sequencer for the hardware register bus (7-bit `register_index`, 16-bit data, one-cycle read latency). It lets a second bus master, such as a debug/loader port, share the peripheral register space with the Lisp core. It serialises the two masters' requests with round-robin fairness and drives one strobe per transaction. It also captures the read value and returns it with a one-cycle acknowledge to the master that was granted.

---
 rtl/regbus_arbiter_if.sv | 30 +++
 rtl/regbus_arbiter.sv | 80 ++++++++
 tb/tb_regbus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regbus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the register bus.
// The arbiter takes the slave modport; the surrounding environment takes master.
interface regbus_arbiter_if #(
  parameter int INDEX_WIDTH = 7,
  parameter int DATA_WIDTH  = 16
);
  logic                   req0, req1;
  logic                   we0, we1;
  logic [INDEX_WIDTH-1:0] index0, index1;
  logic [DATA_WIDTH-1:0]  wdata0, wdata1;
  logic                   ack0, ack1;
  logic [DATA_WIDTH-1:0]  rdata0, rdata1;
  logic [INDEX_WIDTH-1:0] register_index;
  logic                   register_read;
  logic                   register_write;
  logic [DATA_WIDTH-1:0]  register_write_value;
  logic [DATA_WIDTH-1:0]  register_read_value;

  modport slave (
    input  req0, req1, we0, we1, index0, index1, wdata0, wdata1, register_read_value,
    output ack0, ack1, rdata0, rdata1,
           register_index, register_read, register_write, register_write_value
  );

  modport master (
    output req0, req1, we0, we1, index0, index1, wdata0, wdata1, register_read_value,
    input  ack0, ack1, rdata0, rdata1,
           register_index, register_read, register_write, register_write_value
  );
endinterface

// File: rtl/regbus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the register bus: one strobe per
// transaction, read data captured one cycle after the strobe, one-cycle ack.
module regbus_arbiter #(
  parameter int INDEX_WIDTH = 7,
  parameter int DATA_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  regbus_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0] state;
  logic       last_grant;
  logic       gnt;
  logic       we_q;

  // Master 1 wins when alone, or on a tie when master 0 was served last.
  logic                   pick1;
  logic                   win_we;
  logic [INDEX_WIDTH-1:0] win_index;
  logic [DATA_WIDTH-1:0]  win_wdata;

  assign pick1     = bus.req1 && (!bus.req0 || !last_grant);
  assign win_we    = pick1 ? bus.we1    : bus.we0;
  assign win_index = pick1 ? bus.index1 : bus.index0;
  assign win_wdata = pick1 ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                    <= IDLE;
      last_grant               <= 1'b1;
      gnt                      <= 1'b0;
      we_q                     <= 1'b0;
      bus.register_index       <= '0;
      bus.register_write_value <= '0;
      bus.register_read        <= 1'b0;
      bus.register_write       <= 1'b0;
      bus.ack0                 <= 1'b0;
      bus.ack1                 <= 1'b0;
      bus.rdata0               <= '0;
      bus.rdata1               <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses.
      bus.register_read  <= 1'b0;
      bus.register_write <= 1'b0;
      bus.ack0           <= 1'b0;
      bus.ack1           <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt                      <= pick1;
            last_grant               <= pick1;
            we_q                     <= win_we;
            bus.register_index       <= win_index;
            bus.register_write_value <= win_wdata;
            bus.register_write       <= win_we;
            bus.register_read        <= !win_we;
            state                    <= ACCESS;
          end
        end
        ACCESS: state <= WAIT;
        WAIT: begin
          // Read data is valid on the bus during this cycle.
          if (!we_q) begin
            if (gnt) bus.rdata1 <= bus.register_read_value;
            else     bus.rdata0 <= bus.register_read_value;
          end
          bus.ack0 <= !gnt;
          bus.ack1 <= gnt;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regbus_arbiter.sv
// Bench for regbus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grants, bus traffic and rdata.
module tb_regbus_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regbus_arbiter_if #(.INDEX_WIDTH(7), .DATA_WIDTH(16)) bus ();

  regbus_arbiter #(.INDEX_WIDTH(7), .DATA_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] init_val(input logic [6:0] i);
    init_val = 16'hA5C3 ^ {i, 9'h000} ^ {9'h000, i};
  endfunction

  // Register-file responder: one-cycle read latency, optional forced read value.
  logic [15:0] mem [128];
  bit          wr_seen [128];
  bit          override_en = 1'b0;
  logic [15:0] override_val = 16'h0;
  always @(posedge clk) begin
    if (bus.register_read)
      bus.register_read_value <= override_en ? override_val :
        (wr_seen[bus.register_index] ? mem[bus.register_index] : init_val(bus.register_index));
    if (bus.register_write) begin
      mem[bus.register_index]     <= bus.register_write_value;
      wr_seen[bus.register_index] <= 1'b1;
    end
  end

  bit overlap_seen = 1'b0;
  always @(negedge clk) begin
    if (bus.register_read && bus.register_write) overlap_seen <= 1'b1;
    if (bus.ack0 && bus.ack1) overlap_seen <= 1'b1;
  end

  // Reference model state
  bit          m_last;
  logic [15:0] exp_rd0, exp_rd1;
  logic [15:0] exp_mem [128];
  bit          exp_seen [128];

  function automatic logic [15:0] model_read(input logic [6:0] i);
    model_read = exp_seen[i] ? exp_mem[i] : init_val(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.index0 = '0; bus.index1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    tick(); tick();
    checks++;
    if ({bus.register_read, bus.register_write, bus.ack0, bus.ack1} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got %b want 0000",
        {bus.register_read, bus.register_write, bus.ack0, bus.ack1});
    end
    checks++;
    if (bus.register_index !== 7'h0) begin
      errors++; $display("FAIL reset_index got %h want 00", bus.register_index);
    end
    checks++;
    if (bus.register_write_value !== 16'h0) begin
      errors++; $display("FAIL reset_wvalue got %h want 0000", bus.register_write_value);
    end
    checks++;
    if ({bus.rdata0, bus.rdata1} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h/%h want 0/0", bus.rdata0, bus.rdata1);
    end
    reset_n = 1;
    tick();
    m_last = 1; exp_rd0 = 0; exp_rd1 = 0;
  endtask

  task automatic test_single_read();
    override_en = 1; override_val = 16'hBEEF;
    bus.req0 = 1; bus.we0 = 0; bus.index0 = 7'h05;
    tick();
    checks++;
    if (bus.register_read !== 1 || bus.register_write !== 0 || bus.register_index !== 7'h05) begin
      errors++; $display("FAIL read_strobe got rd=%b wr=%b idx=%h want rd=1 wr=0 idx=05",
        bus.register_read, bus.register_write, bus.register_index);
    end
    tick();
    checks++;
    if (bus.register_read !== 0 || bus.ack0 !== 0) begin
      errors++; $display("FAIL read_wait got rd=%b ack0=%b want 0 0", bus.register_read, bus.ack0);
    end
    tick();
    checks++;
    if (bus.ack0 !== 1 || bus.ack1 !== 0 || bus.rdata0 !== 16'hBEEF) begin
      errors++; $display("FAIL read_ack got ack0=%b ack1=%b rdata0=%h want 1 0 beef",
        bus.ack0, bus.ack1, bus.rdata0);
    end
    bus.req0 = 0;
    tick();
    checks++;
    if (bus.ack0 !== 0 || bus.rdata0 !== 16'hBEEF) begin
      errors++; $display("FAIL read_after got ack0=%b rdata0=%h want 0 beef", bus.ack0, bus.rdata0);
    end
    override_en = 0;
    m_last = 0; exp_rd0 = 16'hBEEF;
  endtask

  task automatic test_single_write();
    bus.req1 = 1; bus.we1 = 1; bus.index1 = 7'h7F; bus.wdata1 = 16'h1234;
    tick();
    checks++;
    if (bus.register_write !== 1 || bus.register_read !== 0 || bus.register_index !== 7'h7F ||
        bus.register_write_value !== 16'h1234) begin
      errors++; $display("FAIL write_strobe got wr=%b rd=%b idx=%h val=%h want 1 0 7f 1234",
        bus.register_write, bus.register_read, bus.register_index, bus.register_write_value);
    end
    tick();
    checks++;
    if (bus.register_write !== 0) begin
      errors++; $display("FAIL write_single got wr=%b want 0", bus.register_write);
    end
    tick();
    checks++;
    if (bus.ack1 !== 1 || bus.ack0 !== 0 || bus.rdata1 !== exp_rd1) begin
      errors++; $display("FAIL write_ack got ack1=%b ack0=%b rdata1=%h want 1 0 %h",
        bus.ack1, bus.ack0, bus.rdata1, exp_rd1);
    end
    bus.req1 = 0;
    tick();
    m_last = 1; exp_mem[7'h7F] = 16'h1234; exp_seen[7'h7F] = 1;
  endtask

  task automatic test_contention();
    int strobes[$];
    int grants[$];
    bit exp_g;
    bus.req0 = 1; bus.we0 = 0; bus.index0 = 7'h10;
    bus.req1 = 1; bus.we1 = 0; bus.index1 = 7'h20;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.register_read || bus.register_write) strobes.push_back(c);
      if (bus.ack0 || bus.ack1) begin
        exp_g = !m_last;
        m_last = exp_g;
        checks++;
        if (bus.ack1 !== exp_g || bus.ack0 !== !exp_g) begin
          errors++; $display("FAIL contention_grant n=%0d got ack0=%b ack1=%b want master %0d",
            grants.size(), bus.ack0, bus.ack1, exp_g);
        end
        if (exp_g) exp_rd1 = model_read(7'h20); else exp_rd0 = model_read(7'h10);
        checks++;
        if (bus.rdata0 !== exp_rd0 || bus.rdata1 !== exp_rd1) begin
          errors++; $display("FAIL contention_rdata got %h/%h want %h/%h",
            bus.rdata0, bus.rdata1, exp_rd0, exp_rd1);
        end
        grants.push_back(int'(exp_g));
        if (grants.size() == 4) begin bus.req0 = 0; bus.req1 = 0; end
      end
    end
    checks++;
    if (grants.size() != 4) begin
      errors++; $display("FAIL contention_count got %0d acks want 4", grants.size());
    end
    checks++;
    if (strobes.size() != 4) begin
      errors++; $display("FAIL contention_strobes got %0d strobes want 4", strobes.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (strobes[i] != 1 + 4 * i) begin
          errors++; $display("FAIL contention_spacing n=%0d got cycle %0d want %0d",
            i, strobes[i], 1 + 4 * i);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    bus.req0 = 1; bus.we0 = 1; bus.index0 = 7'h01; bus.wdata0 = 16'h1001;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.register_write) begin
        checks++;
        if (c != 1 + 4 * k || bus.register_index !== 7'(k + 1) ||
            bus.register_write_value !== 16'(16'h1001 + k)) begin
          errors++; $display("FAIL b2b_strobe got cycle %0d idx=%h val=%h want cycle %0d idx=%h",
            c, bus.register_index, bus.register_write_value, 1 + 4 * k, k + 1);
        end
      end
      if (bus.ack0) begin
        checks++;
        if (bus.rdata0 !== exp_rd0) begin
          errors++; $display("FAIL b2b_rdata_held got %h want %h", bus.rdata0, exp_rd0);
        end
        exp_mem[7'(k + 1)] = 16'(16'h1001 + k); exp_seen[7'(k + 1)] = 1;
        k++;
        if (k < 3) begin bus.index0 = 7'(k + 1); bus.wdata0 = 16'(16'h1001 + k); end
        else bus.req0 = 0;
      end
    end
    checks++;
    if (k != 3) begin
      errors++; $display("FAIL b2b_count got %0d acks want 3", k);
    end
    m_last = 0;
  endtask

  task automatic test_reset_mid();
    bus.req1 = 1; bus.we1 = 1; bus.index1 = 7'h33; bus.wdata1 = 16'hCAFE;
    tick();
    checks++;
    if (bus.register_write !== 1) begin
      errors++; $display("FAIL rstmid_pre got wr=%b want 1", bus.register_write);
    end
    #1 reset_n = 0;
    #1;
    checks++;
    if (bus.register_write !== 0 || bus.ack1 !== 0) begin
      errors++; $display("FAIL rstmid_async got wr=%b ack1=%b want 0 0", bus.register_write, bus.ack1);
    end
    tick(); tick();
    checks++;
    if (bus.ack1 !== 0 || bus.ack0 !== 0) begin
      errors++; $display("FAIL rstmid_noack got ack0=%b ack1=%b want 0 0", bus.ack0, bus.ack1);
    end
    exp_rd0 = 0; exp_rd1 = 0; m_last = 1;
    bus.req0 = 1; bus.we0 = 0; bus.index0 = 7'h33;
    reset_n = 1;
    tick();
    checks++;
    if (bus.register_read !== 1 || bus.register_write !== 0 || bus.register_index !== 7'h33) begin
      errors++; $display("FAIL rstmid_regrant got rd=%b wr=%b idx=%h want master0 read 33",
        bus.register_read, bus.register_write, bus.register_index);
    end
    tick(); tick();
    exp_rd0 = model_read(7'h33);
    checks++;
    if (bus.ack0 !== 1 || bus.ack1 !== 0 || bus.rdata0 !== exp_rd0) begin
      errors++; $display("FAIL rstmid_ack got ack0=%b ack1=%b rdata0=%h want 1 0 %h",
        bus.ack0, bus.ack1, bus.rdata0, exp_rd0);
    end
    bus.req0 = 0;
    tick(); tick();
    checks++;
    if (bus.register_write !== 1 || bus.register_write_value !== 16'hCAFE) begin
      errors++; $display("FAIL rstmid_retry got wr=%b val=%h want 1 cafe",
        bus.register_write, bus.register_write_value);
    end
    tick(); tick();
    checks++;
    if (bus.ack1 !== 1 || bus.rdata1 !== 16'h0) begin
      errors++; $display("FAIL rstmid_retry_ack got ack1=%b rdata1=%h want 1 0000", bus.ack1, bus.rdata1);
    end
    bus.req1 = 0;
    tick();
    exp_mem[7'h33] = 16'hCAFE; exp_seen[7'h33] = 1; m_last = 1;
  endtask

  task automatic test_random();
    bit r0, r1, w0, w1, g, ew;
    logic [6:0] i0, i1, ei;
    logic [15:0] d0, d1, ed;
    for (int n = 0; n < 40; n++) begin
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      i0 = 7'($urandom_range(0, 127)); i1 = 7'($urandom_range(0, 127));
      d0 = 16'($urandom); d1 = 16'($urandom);
      bus.req0 = r0; bus.we0 = w0; bus.index0 = i0; bus.wdata0 = d0;
      bus.req1 = r1; bus.we1 = w1; bus.index1 = i1; bus.wdata1 = d1;
      if (!r0 && !r1) begin
        tick();
        checks++;
        if ({bus.register_read, bus.register_write, bus.ack0, bus.ack1} !== 4'b0) begin
          errors++; $display("FAIL rand_idle n=%0d got %b want 0000", n,
            {bus.register_read, bus.register_write, bus.ack0, bus.ack1});
        end
        continue;
      end
      g  = (r0 && r1) ? !m_last : r1;
      ew = g ? w1 : w0;
      ei = g ? i1 : i0;
      ed = g ? d1 : d0;
      tick();
      checks++;
      if (bus.register_read !== !ew || bus.register_write !== ew || bus.register_index !== ei ||
          (ew && bus.register_write_value !== ed)) begin
        errors++; $display("FAIL rand_strobe n=%0d got rd=%b wr=%b idx=%h val=%h want rd=%b wr=%b idx=%h val=%h",
          n, bus.register_read, bus.register_write, bus.register_index, bus.register_write_value,
          !ew, ew, ei, ed);
      end
      tick();
      checks++;
      if (bus.register_read !== 0 || bus.register_write !== 0 || bus.register_index !== ei) begin
        errors++; $display("FAIL rand_wait n=%0d got rd=%b wr=%b idx=%h want 0 0 %h",
          n, bus.register_read, bus.register_write, bus.register_index, ei);
      end
      if (!ew) begin
        if (g) exp_rd1 = model_read(ei); else exp_rd0 = model_read(ei);
      end else begin
        exp_mem[ei] = ed; exp_seen[ei] = 1;
      end
      tick();
      checks++;
      if (bus.ack0 !== !g || bus.ack1 !== g || bus.rdata0 !== exp_rd0 || bus.rdata1 !== exp_rd1) begin
        errors++; $display("FAIL rand_ack n=%0d got ack=%b%b rdata=%h/%h want ack=%b%b rdata=%h/%h",
          n, bus.ack1, bus.ack0, bus.rdata0, bus.rdata1, g, !g, exp_rd0, exp_rd1);
      end
      m_last = g;
      bus.req0 = 0; bus.req1 = 0;
      tick();
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap_seen !== 1'b0) begin
      errors++; $display("FAIL no_overlap got overlap=%b want 0", overlap_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_no_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
